// File: rtl/mini_calc_arbiter_if.sv
// Handshake and calculator bus of mini_calc_arbiter: two requesters, one response
// channel, and the drive/return signals of the shared calculator.
interface mini_calc_arbiter_if #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int INSTR_BIT_WIDTH = 4
);
  logic                       Req0Valid;
  logic                       Req0Ready;
  logic [INSTR_BIT_WIDTH-1:0] Req0Instr;
  logic [INPUT_BIT_WIDTH-1:0] Req0A;
  logic [INPUT_BIT_WIDTH-1:0] Req0B;
  logic                       Req1Valid;
  logic                       Req1Ready;
  logic [INSTR_BIT_WIDTH-1:0] Req1Instr;
  logic [INPUT_BIT_WIDTH-1:0] Req1A;
  logic [INPUT_BIT_WIDTH-1:0] Req1B;
  logic                       RspValid;
  logic                       RspReady;
  logic                       RspId;
  logic [INPUT_BIT_WIDTH-1:0] RspA;
  logic [INPUT_BIT_WIDTH-1:0] RspB;
  logic [INSTR_BIT_WIDTH-1:0] CalcInstruction;
  logic [INPUT_BIT_WIDTH-1:0] CalcInputA;
  logic [INPUT_BIT_WIDTH-1:0] CalcInputB;
  logic [INPUT_BIT_WIDTH-1:0] CalcOutputA;
  logic [INPUT_BIT_WIDTH-1:0] CalcOutputB;
  logic                       Busy;

  modport slave (
    input  Req0Valid, Req0Instr, Req0A, Req0B,
    input  Req1Valid, Req1Instr, Req1A, Req1B,
    input  RspReady, CalcOutputA, CalcOutputB,
    output Req0Ready, Req1Ready, RspValid, RspId, RspA, RspB,
    output CalcInstruction, CalcInputA, CalcInputB, Busy
  );

  modport master (
    output Req0Valid, Req0Instr, Req0A, Req0B,
    output Req1Valid, Req1Instr, Req1A, Req1B,
    output RspReady, CalcOutputA, CalcOutputB,
    input  Req0Ready, Req1Ready, RspValid, RspId, RspA, RspB,
    input  CalcInstruction, CalcInputA, CalcInputB, Busy
  );
endinterface

// File: rtl/mini_calc_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency calculator.
// Define MINI_CALC_ARB_ROUND_ROBIN_EN for round-robin; otherwise requester 0 has fixed priority.
module mini_calc_arbiter #(
  parameter int                         INPUT_BIT_WIDTH = 8,
  parameter int                         INSTR_BIT_WIDTH = 4,
  parameter int                         CALC_LATENCY    = 2,
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP  = 4'b1111
) (
  input logic                 Clk,
  input logic                 Rst_n,
  mini_calc_arbiter_if.slave  bus
);

  if (CALC_LATENCY < 1 || CALC_LATENCY > 15) begin : g_bad_latency
    $error("mini_calc_arbiter: CALC_LATENCY must be within 1..15");
  end

  localparam logic [3:0] LAT_LD = 4'(CALC_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [INSTR_BIT_WIDTH-1:0] instr_q, instr_d;
  logic [INPUT_BIT_WIDTH-1:0] a_q, a_d;
  logic [INPUT_BIT_WIDTH-1:0] b_q, b_d;
  logic                       id_q, id_d;
  logic [INPUT_BIT_WIDTH-1:0] rsp_a_q, rsp_a_d;
  logic [INPUT_BIT_WIDTH-1:0] rsp_b_q, rsp_b_d;
  logic                       gnt1;
  logic                       rdy0;
  logic                       rdy1;

`ifdef MINI_CALC_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Ready is gated by Rst_n so nothing is accepted while reset is held.
  always_comb begin
`ifdef MINI_CALC_ARB_ROUND_ROBIN_EN
    gnt1 = bus.Req1Valid && (!bus.Req0Valid || ptr_q);
`else
    gnt1 = bus.Req1Valid && !bus.Req0Valid;
`endif
    rdy0 = Rst_n && (state_q == IDLE) && bus.Req0Valid && !gnt1;
    rdy1 = Rst_n && (state_q == IDLE) && gnt1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    rsp_a_d = rsp_a_q;
    rsp_b_d = rsp_b_q;
`ifdef MINI_CALC_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (rdy0 || rdy1) begin
          instr_d = rdy1 ? bus.Req1Instr : bus.Req0Instr;
          a_d     = rdy1 ? bus.Req1A     : bus.Req0A;
          b_d     = rdy1 ? bus.Req1B     : bus.Req0B;
          id_d    = rdy1;
          cnt_d   = LAT_LD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_a_d = bus.CalcOutputA;
          rsp_b_d = bus.CalcOutputB;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.RspReady) begin
          state_d = IDLE;
`ifdef MINI_CALC_ARB_ROUND_ROBIN_EN
          ptr_d   = ~id_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= CODE_INSTR_NOP;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
    end
  end

  assign bus.Req0Ready       = rdy0;
  assign bus.Req1Ready       = rdy1;
  assign bus.RspValid        = (state_q == RESP);
  assign bus.RspId           = id_q;
  assign bus.RspA            = rsp_a_q;
  assign bus.RspB            = rsp_b_q;
  assign bus.Busy            = (state_q != IDLE);
  assign bus.CalcInstruction = (state_q == EXEC) ? instr_q : CODE_INSTR_NOP;
  assign bus.CalcInputA      = (state_q == EXEC) ? a_q : '0;
  assign bus.CalcInputB      = (state_q == EXEC) ? b_q : '0;

endmodule

// File: tb/tb_mini_calc_arbiter.sv
// Bench for mini_calc_arbiter: transaction-level reference model with per-cycle compare,
// directed scenarios, random traffic, and a second CALC_LATENCY=1 instance.
module tb_mini_calc_arbiter;

  localparam int LAT = 2;

  logic Clk    = 1'b0;
  logic Rst_n  = 1'b0;
  logic Rst1_n = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   chk_en   = 1'b0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  mini_calc_arbiter_if #(.INPUT_BIT_WIDTH(8), .INSTR_BIT_WIDTH(4)) bus  ();
  mini_calc_arbiter_if #(.INPUT_BIT_WIDTH(8), .INSTR_BIT_WIDTH(4)) bus1 ();

  mini_calc_arbiter #(
    .INPUT_BIT_WIDTH(8), .INSTR_BIT_WIDTH(4), .CALC_LATENCY(LAT), .CODE_INSTR_NOP(4'b1111)
  ) u_dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  mini_calc_arbiter #(
    .INPUT_BIT_WIDTH(8), .INSTR_BIT_WIDTH(4), .CALC_LATENCY(1), .CODE_INSTR_NOP(4'b1111)
  ) u_dut1 (.Clk(Clk), .Rst_n(Rst1_n), .bus(bus1));

  // Calculator behaviour: divide/modulo, compare, NOP marker, add/xor otherwise.
  function automatic logic [15:0] calc_f(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      4'b1110: return (b == 8'd0) ? {8'hFF, a} : {a / b, a % b};
      4'b1101: return {7'd0, a < b, 7'd0, a == b};
      4'b1111: return 16'hA55A;
      default: return {a + b, a ^ b};
    endcase
  endfunction

  // Main calculator: result reflects inputs presented LAT-1 edges earlier.
  logic [19:0] cpipe [0:15];
  logic [19:0] cin;
  always @(posedge Clk) begin
    cpipe[0] <= {bus.CalcInstruction, bus.CalcInputA, bus.CalcInputB};
    for (int i = 1; i < 16; i++) cpipe[i] <= cpipe[i-1];
  end
  always_comb begin
    cin = (LAT == 1) ? {bus.CalcInstruction, bus.CalcInputA, bus.CalcInputB}
                     : cpipe[(LAT >= 2) ? LAT - 2 : 0];
    {bus.CalcOutputA, bus.CalcOutputB} = calc_f(cin[19:16], cin[15:8], cin[7:0]);
  end
  always_comb
    {bus1.CalcOutputA, bus1.CalcOutputB} = calc_f(bus1.CalcInstruction, bus1.CalcInputA, bus1.CalcInputB);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       id;
    logic [3:0] instr;
    logic [7:0] a;
    logic [7:0] b;
  } txn_t;

  bit         m_active = 1'b0;
  int         m_age    = 0;
  txn_t       m_txn    = '0;
  logic [7:0] m_ra     = '0;
  logic [7:0] m_rb     = '0;
  logic       m_rid    = 1'b0;
  logic       m_ptr    = 1'b0;

  function automatic int winner(logic v0, logic v1, logic ptr);
    if (v0 && v1) begin
`ifdef MINI_CALC_ARB_ROUND_ROBIN_EN
      return ptr ? 1 : 0;
`else
      return (ptr === 1'bx) ? 0 : 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_ra     <= '0;
      m_rb     <= '0;
      m_rid    <= 1'b0;
      m_ptr    <= 1'b0;
    end else if (!m_active) begin
      case (winner(bus.Req0Valid, bus.Req1Valid, m_ptr))
        0: begin
          m_active <= 1'b1; m_age <= 1; m_rid <= 1'b0;
          m_txn <= '{id: 1'b0, instr: bus.Req0Instr, a: bus.Req0A, b: bus.Req0B};
        end
        1: begin
          m_active <= 1'b1; m_age <= 1; m_rid <= 1'b1;
          m_txn <= '{id: 1'b1, instr: bus.Req1Instr, a: bus.Req1A, b: bus.Req1B};
        end
        default: ;
      endcase
    end else if (m_age <= LAT) begin
      if (m_age == LAT) {m_ra, m_rb} <= calc_f(m_txn.instr, m_txn.a, m_txn.b);
      m_age <= m_age + 1;
    end else if (bus.RspReady) begin
      m_active <= 1'b0;
      m_ptr    <= ~m_txn.id;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      bit exec;
      int w;
      exec = m_active && (m_age <= LAT);
      w    = winner(bus.Req0Valid, bus.Req1Valid, m_ptr);
      chk("Busy",      bus.Busy,      m_active);
      chk("RspValid",  bus.RspValid,  m_active && (m_age == LAT + 1));
      chk("Req0Ready", bus.Req0Ready, Rst_n && !m_active && (w == 0));
      chk("Req1Ready", bus.Req1Ready, Rst_n && !m_active && (w == 1));
      chk("CalcInstruction", bus.CalcInstruction, exec ? m_txn.instr : 4'b1111);
      chk("CalcInputA", bus.CalcInputA, exec ? m_txn.a : 8'd0);
      chk("CalcInputB", bus.CalcInputB, exec ? m_txn.b : 8'd0);
      chk("RspA",  bus.RspA,  m_ra);
      chk("RspB",  bus.RspB,  m_rb);
      chk("RspId", bus.RspId, m_rid);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Req0Valid = 1'b0; bus.Req0Instr = '0; bus.Req0A = '0; bus.Req0B = '0;
    bus.Req1Valid = 1'b0; bus.Req1Instr = '0; bus.Req1A = '0; bus.Req1B = '0;
    bus.RspReady  = 1'b1;
  endtask

  // Cycles from the current accept edge until RspValid is first seen.
  task automatic wait_rsp(input string nm, input int exp_n);
    int n;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (bus.RspValid) begin
        n = k;
        break;
      end
    end
    chk(nm, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int acc[$];
    int rv[$];
    int exp_g;

    idle_inputs();
    bus.Req0Valid = 1'b1;
    bus.Req1Valid = 1'b1;
    bus1.Req0Valid = 1'b0; bus1.Req0Instr = '0; bus1.Req0A = '0; bus1.Req0B = '0;
    bus1.Req1Valid = 1'b0; bus1.Req1Instr = '0; bus1.Req1A = '0; bus1.Req1B = '0;
    bus1.RspReady  = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
    @(negedge Clk);
    chk("rst_Req0Ready", bus.Req0Ready, 1'b0);
    chk("rst_CalcInstruction", bus.CalcInstruction, 4'b1111);
    chk("rst_Busy", bus.Busy, 1'b0);
    tick();
    idle_inputs();
    Rst_n = 1'b1;
    tick();

    // Scenario 1: compare instruction from requester 0.
    bus.Req0Valid = 1'b1; bus.Req0Instr = 4'b1101; bus.Req0A = 8'd16; bus.Req0B = 8'd16;
    @(negedge Clk);
    chk("s1_Req0Ready", bus.Req0Ready, 1'b1);
    tick();
    bus.Req0Valid = 1'b0;
    wait_rsp("s1_rsp_latency", 3);
    chk("s1_RspId", bus.RspId, 1'b0);
    chk("s1_RspA", bus.RspA, 8'h00);
    chk("s1_RspB", bus.RspB, 8'h01);
    tick();
    repeat (2) tick();

    // Scenarios 2 and 4: divide from requester 1, response held for 5 cycles.
    bus.Req1Valid = 1'b1; bus.Req1Instr = 4'b1110; bus.Req1A = 8'd100; bus.Req1B = 8'd7;
    @(negedge Clk);
    chk("s2_Req1Ready", bus.Req1Ready, 1'b1);
    tick();
    bus.Req1Valid = 1'b0;
    bus.RspReady  = 1'b0;
    wait_rsp("s2_rsp_latency", 3);
    tick();
    bus.Req0Valid = 1'b1;
    bus.Req1Valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("s4_RspValid", bus.RspValid, 1'b1);
      chk("s4_RspId", bus.RspId, 1'b1);
      chk("s4_RspA", bus.RspA, 8'd14);
      chk("s4_RspB", bus.RspB, 8'd2);
      chk("s4_Ready", {bus.Req0Ready, bus.Req1Ready}, 2'b00);
      chk("s4_CalcInstruction", bus.CalcInstruction, 4'b1111);
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    // Scenario 5: reset during EXEC.
    bus.Req0Valid = 1'b1; bus.Req0Instr = 4'b0011; bus.Req0A = 8'd5; bus.Req0B = 8'd9;
    tick();
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("s5_Busy", bus.Busy, 1'b0);
    chk("s5_RspValid", bus.RspValid, 1'b0);
    chk("s5_CalcInstruction", bus.CalcInstruction, 4'b1111);
    chk("s5_CalcInputA", bus.CalcInputA, 8'd0);
    chk("s5_Req0Ready", bus.Req0Ready, 1'b0);
    chk("s5_RspAB", {bus.RspA, bus.RspB}, 16'h0000);
    tick();
    idle_inputs();
    Rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      chk("s5_no_rsp", bus.RspValid, 1'b0);
      tick();
    end
    bus.Req1Valid = 1'b1; bus.Req1Instr = 4'b1110; bus.Req1A = 8'd50; bus.Req1B = 8'd6;
    tick();
    bus.Req1Valid = 1'b0;
    wait_rsp("s5_rsp_latency", 3);
    chk("s5_RspA", bus.RspA, 8'd8);
    chk("s5_RspB", bus.RspB, 8'd2);
    tick();

    // Scenario 3: both requesters always valid, starting from reset.
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    bus.Req0Valid = 1'b1; bus.Req1Valid = 1'b1; bus.RspReady = 1'b1;
    for (int k = 0; k < 40 && grants.size() < 4; k++) begin
      bus.Req0A = 8'($urandom); bus.Req1A = 8'($urandom);
      @(negedge Clk);
      if (bus.Req0Ready) grants.push_back(0);
      if (bus.Req1Ready) grants.push_back(1);
      tick();
    end
    chk("s3_grant_count", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++) begin
`ifdef MINI_CALC_ARB_ROUND_ROBIN_EN
      exp_g = k % 2;
`else
      exp_g = 0;
`endif
      chk("s3_grant", grants[k], exp_g);
    end
    idle_inputs();
    repeat (6) tick();

    // Random traffic against the model, with occasional reset pulses.
    for (int k = 0; k < 500; k++) begin
      bus.Req0Valid = ($urandom_range(0, 99) < 45);
      bus.Req0Instr = 4'($urandom);
      bus.Req0A     = 8'($urandom);
      bus.Req0B     = 8'($urandom);
      bus.Req1Valid = ($urandom_range(0, 99) < 45);
      bus.Req1Instr = 4'($urandom);
      bus.Req1A     = 8'($urandom);
      bus.Req1B     = 8'($urandom);
      bus.RspReady  = ($urandom_range(0, 99) < 60);
      Rst_n         = ($urandom_range(0, 149) != 0);
      tick();
    end
    Rst_n = 1'b1;
    idle_inputs();
    repeat (6) tick();

    // Scenario 6: CALC_LATENCY=1 instance, requester 0 always valid.
    bus1.Req0Valid = 1'b1; bus1.Req0Instr = 4'b1110; bus1.Req0A = 8'd9; bus1.Req0B = 8'd4;
    bus1.RspReady  = 1'b1;
    tick();
    Rst1_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (bus1.Req0Valid && bus1.Req0Ready) acc.push_back(cyc);
      if (bus1.RspValid) begin
        rv.push_back(cyc);
        chk("s6_RspAB", {bus1.RspA, bus1.RspB}, {8'd2, 8'd1});
      end
    end
    chk("s6_accept_count", acc.size() >= 3, 1'b1);
    chk("s6_rsp_count", rv.size() >= 2, 1'b1);
    if (acc.size() >= 3 && rv.size() >= 2) begin
      chk("s6_spacing01", acc[1] - acc[0], 3);
      chk("s6_spacing12", acc[2] - acc[1], 3);
      chk("s6_latency0", rv[0] - acc[0], 2);
      chk("s6_latency1", rv[1] - acc[1], 2);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mini_calc_arbiter.md
MINI_CALC_ARBITER -- requirements
Module: mini_calc_arbiter

Interface
REQ-001 Parameter INPUT_BIT_WIDTH, default 8: operand and result width.
REQ-002 Parameter INSTR_BIT_WIDTH, default 4: instruction width.
REQ-003 Parameter CALC_LATENCY, default 2, legal range 1..15: cycles from the calculator inputs becoming stable to its outputs being valid.
REQ-004 Parameter CODE_INSTR_NOP, default 4'b1111: instruction driven to the calculator while idle.
REQ-005 Clk  in  1  single clock; all state changes on rising edge.
REQ-006 Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 Req0Valid / Req1Valid  in  1  requester 0/1 holds a valid operation.
REQ-008 Req0Ready / Req1Ready  out  1  arbiter accepts requester 0/1 this cycle.
REQ-009 Req0Instr / Req1Instr  in  INSTR_BIT_WIDTH  requested instruction.
REQ-010 Req0A, Req0B, Req1A, Req1B  in  INPUT_BIT_WIDTH  operands.
REQ-011 RspValid  out  1  result available.
REQ-012 RspReady  in  1  consumer takes the result.
REQ-013 RspId  out  1  requester index owning the result.
REQ-014 RspA / RspB  out  INPUT_BIT_WIDTH  captured calculator outputs A and B.
REQ-015 CalcInstruction  out  INSTR_BIT_WIDTH  drives the shared calculator's instruction input.
REQ-016 CalcInputA / CalcInputB  out  INPUT_BIT_WIDTH  drive the calculator's operand inputs.
REQ-017 CalcOutputA / CalcOutputB  in  INPUT_BIT_WIDTH  calculator results.
REQ-018 Busy  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020 In IDLE, ReqNReady SHALL be asserted combinationally only for the arbitration winner, and only when that requester's ReqNValid is high; both Ready outputs SHALL be low in EXEC and RESP.
REQ-021 When exactly one requester is valid in IDLE, that requester SHALL win.
REQ-022 When both requesters are valid in IDLE, the priority pointer SHALL select the winner (see Configuration).
REQ-023 On a Valid&&Ready handshake, the arbiter SHALL register the instruction, both operands and the requester id, load the counter with CALC_LATENCY, and enter EXEC on the next edge.
REQ-024 In EXEC, CalcInstruction, CalcInputA and CalcInputB SHALL be driven from the registered values.
REQ-025 In IDLE and RESP, CalcInstruction SHALL be CODE_INSTR_NOP and CalcInputA/B SHALL be 0.
REQ-026 The counter SHALL decrement once per cycle in EXEC.
REQ-027 When the counter equals 1, CalcOutputA/B SHALL be captured into RspA/RspB and the FSM SHALL enter RESP; EXEC therefore lasts exactly CALC_LATENCY cycles.
REQ-028 In RESP, RspValid SHALL be 1, and RspA, RspB and RspId SHALL be held stable until RspReady is high.
REQ-029 On a RspValid&&RspReady handshake, the FSM SHALL enter IDLE and the priority pointer SHALL update.
REQ-030 No new request SHALL be accepted in the cycle the response handshake completes.
REQ-031 The minimum issue-to-issue spacing SHALL be CALC_LATENCY+2 cycles.
REQ-032 Requester inputs SHALL be ignored outside the accept cycle.
REQ-033 Instructions SHALL pass through unmodified; no opcode decode is performed.
REQ-034 RspA/RspB SHALL be stored exactly as received, with no width change or truncation.

Reset
REQ-035 While Rst_n is low: state = IDLE, counter = 0, priority pointer = requester 0, RspValid = 0, RspId = 0, RspA = RspB = 0, Busy = 0, both ReqNReady = 0, CalcInstruction = CODE_INSTR_NOP, CalcInputA/B = 0.
REQ-036 Reset asserted in EXEC or RESP SHALL abort the operation immediately; no response is produced for it after release.
REQ-037 The first acceptance SHALL occur no earlier than the first rising edge after Rst_n deasserts.

Configuration
REQ-038 Macro MINI_CALC_ARB_ROUND_ROBIN_EN defined: on both-valid, the pointer's requester wins; after each response handshake the pointer SHALL be set to the requester that was not served.
REQ-039 Macro MINI_CALC_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins on both-valid; the pointer register SHALL be omitted.

Verification
REQ-040 Setup: bench uses a behavioural calculator model with CALC_LATENCY=2, widths 8/4.
REQ-041 Scenario 1: Req0 Instr=4'b1101, A=16, B=16; calc model returns A=8'h00, B=8'h01 -> Req0Ready same cycle; RspValid 3 cycles after accept with RspId=0, RspA=8'h00, RspB=8'h01.
REQ-042 Scenario 2: Req1 Instr=4'b1110, A=100, B=7; model returns 14/2 -> RspId=1, RspA=14, RspB=2; CalcInstruction=4'b1111 in all cycles outside EXEC.
REQ-043 Scenario 3: both valid every cycle, RspReady=1 -> with ROUND_ROBIN_EN, grants alternate 0,1,0,1; without it, grants are 0,0,0,0.
REQ-044 Scenario 4: RspReady held low for 5 cycles in RESP -> RspValid/RspA/RspB/RspId stable for all 5 cycles; Req0Ready and Req1Ready remain 0.
REQ-045 Scenario 5: Rst_n pulsed low during EXEC -> all outputs at reset values; no RspValid after release; next request completes normally.
REQ-046 Scenario 6: CALC_LATENCY=1 -> RspValid 2 cycles after accept; back-to-back requests are spaced 3 cycles apart.
